// File: rtl/video_fetch_sched.sv
// Video fetch scheduler: collects four 16-bit DRAM words per 16-pixel group and
// hands each completed group to the renderer at the following group boundary.
module video_fetch_sched (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cend_i,
    input  logic        line_start_i,
    input  logic        fetch_en_i,
    output logic        dram_req_o,
    input  logic        dram_ack_i,
    input  logic        dram_rvalid_i,
    input  logic [15:0] dram_rdata_i,
    output logic        addr_next_o,
    output logic [63:0] pic_bits_o,
    output logic        fetch_sync_o,
    output logic        underrun_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StFull} state_e;

    state_e      state_q, state_d;
    logic [1:0]  widx_q, widx_d;
    logic [3:0]  pixcnt_q, pixcnt_d;
    logic [63:0] shadow_q, shadow_d;
    logic [63:0] pic_q, pic_d;
    logic        win_q, win_d;
    logic        pend_q, pend_d;
    logic        sync_q, sync_d;
    logic        under_q, under_d;
    logic        req, accept, boundary, outstanding;

    always_comb begin
        req         = (state_q == StReq) && !pend_q;
        accept      = req && dram_ack_i;
        boundary    = cend_i && win_q && (pixcnt_q == 4'd15) && !line_start_i;
        // A read is still in flight after this clk unless its data returned now.
        outstanding = accept || ((state_q == StWait) && !dram_rvalid_i);
    end

    always_comb begin
        state_d  = state_q;
        widx_d   = widx_q;
        pixcnt_d = pixcnt_q;
        shadow_d = shadow_q;
        pic_d    = pic_q;
        win_d    = win_q;
        pend_d   = pend_q && !dram_rvalid_i;
        sync_d   = 1'b0;
        under_d  = under_q;

        case (state_q)
            StReq: begin
                if (accept) state_d = StWait;
            end
            StWait: begin
                if (dram_rvalid_i) begin
                    shadow_d[{widx_q, 4'b0000} +: 16] = dram_rdata_i;
                    widx_d  = widx_q + 2'd1;
                    state_d = (widx_q == 2'd3) ? StFull : StReq;
                end
            end
            default: ;
        endcase

        if (cend_i && win_q) pixcnt_d = pixcnt_q + 4'd1;

        if (boundary) begin
            sync_d = 1'b1;
            if (state_q == StFull) begin
                pic_d  = shadow_q;
                widx_d = 2'd0;
                if (fetch_en_i) state_d = StReq;
            end else begin
                // Late group keeps fetching; it is shown next boundary if it completes.
                pic_d   = '0;
                under_d = 1'b1;
            end
            if (!fetch_en_i) begin
                win_d   = 1'b0;
                state_d = StIdle;
                pend_d  = pend_d || outstanding;
            end
        end

        if (line_start_i) begin
            state_d  = StReq;
            widx_d   = 2'd0;
            pixcnt_d = 4'd0;
            shadow_d = '0;
            under_d  = 1'b0;
            win_d    = 1'b1;
            pend_d   = pend_d || outstanding;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            widx_q   <= 2'd0;
            pixcnt_q <= 4'd0;
            shadow_q <= '0;
            pic_q    <= '0;
            win_q    <= 1'b0;
            pend_q   <= 1'b0;
            sync_q   <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            widx_q   <= widx_d;
            pixcnt_q <= pixcnt_d;
            shadow_q <= shadow_d;
            pic_q    <= pic_d;
            win_q    <= win_d;
            pend_q   <= pend_d;
            sync_q   <= sync_d;
            under_q  <= under_d;
        end
    end

    assign dram_req_o   = req;
    assign addr_next_o  = accept;
    assign pic_bits_o   = pic_q;
    assign fetch_sync_o = sync_q;
    assign underrun_o   = under_q;

endmodule
